// File: rtl/seq_det_ctrl.sv
// Word-to-bit serialiser with a programmable pattern detector that spans the words of a frame.
// A closed frame is opened by its first accepted word, which also snapshots the pattern configuration.
module seq_det_ctrl #(
  parameter int DATA_W = 16,
  parameter int PAT_W  = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [PAT_W-1:0]  cfg_pattern,
  input  logic [3:0]        cfg_len,
  input  logic              cfg_overlap,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              bit_out,
  output logic              bit_valid,
  output logic              match_pulse,
  output logic [CNT_W-1:0]  match_count,
  output logic              done,
  output logic              cfg_err
);

  localparam int               IDX_W    = $clog2(DATA_W);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);
  localparam logic [3:0]       LEN_MAX  = 4'(PAT_W);
  localparam logic [3:0]       SEEN_MAX = 4'(PAT_W);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   word_q, word_d;
  logic                last_q, last_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                open_q, open_d;
  logic [PAT_W-1:0]    pat_q, pat_d;
  logic [3:0]          len_q, len_d;
  logic                ovl_q, ovl_d;
  // The newest bit is never stored: it joins the history combinationally for the compare.
  logic [PAT_W-2:0]    hist_q, hist_d;
  logic [3:0]          seen_q, seen_d;
  logic                pulse_q, pulse_d;
  logic [CNT_W-1:0]    count_q, count_d;

  logic                accept;
  logic                cur_bit;
  logic [PAT_W-1:0]    hist_new;
  logic [PAT_W-1:0]    len_mask;
  logic [3:0]          seen_new;
  logic                hit;

  // Live config is only judged while no frame is open; the shadow copy governs otherwise.
  assign cfg_err  = !open_q && ((cfg_len == 4'd0) || (cfg_len > LEN_MAX));
  assign in_ready = reset && (state_q == S_IDLE) && !cfg_err;
  assign accept   = in_valid && in_ready;

  assign cur_bit  = word_q[DATA_W-1];
  assign hist_new = {hist_q, cur_bit};
  assign len_mask = ~({PAT_W{1'b1}} << len_q);
  assign seen_new = (seen_q == SEEN_MAX) ? SEEN_MAX : seen_q + 1'b1;
  assign hit      = (seen_new >= len_q) && (((hist_new ^ pat_q) & len_mask) == '0);

  always_comb begin
    // NOTE: every _d gets its hold value first so no path through the case leaves a latch behind.
    state_d = state_q;
    word_d  = word_q;
    last_d  = last_q;
    idx_d   = idx_q;
    open_d  = open_q;
    pat_d   = pat_q;
    len_d   = len_q;
    ovl_d   = ovl_q;
    hist_d  = hist_q;
    seen_d  = seen_q;
    pulse_d = 1'b0;
    count_d = count_q;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          word_d  = in_data;
          last_d  = in_last;
          idx_d   = '0;
          state_d = S_SHIFT;
          if (!open_q) begin
            open_d  = 1'b1;
            pat_d   = cfg_pattern;
            len_d   = cfg_len;
            ovl_d   = cfg_overlap;
            hist_d  = '0;
            seen_d  = '0;
            count_d = '0;
          end
        end
      end
      S_SHIFT: begin
        word_d = {word_q[DATA_W-2:0], 1'b0};
        hist_d = hist_new[PAT_W-2:0];
        seen_d = (hit && !ovl_q) ? 4'd0 : seen_new;
        if (hit) begin
          pulse_d = 1'b1;
          count_d = (count_q == '1) ? count_q : count_q + 1'b1;
        end
        idx_d = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          state_d = last_q ? S_DONE : S_IDLE;
          if (last_q) open_d = 1'b0;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      word_q  <= '0;
      last_q  <= 1'b0;
      idx_q   <= '0;
      open_q  <= 1'b0;
      pat_q   <= '0;
      len_q   <= '0;
      ovl_q   <= 1'b0;
      hist_q  <= '0;
      seen_q  <= '0;
      pulse_q <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      last_q  <= last_d;
      idx_q   <= idx_d;
      open_q  <= open_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      ovl_q   <= ovl_d;
      hist_q  <= hist_d;
      seen_q  <= seen_d;
      pulse_q <= pulse_d;
      count_q <= count_d;
    end
  end

  assign bit_valid   = (state_q == S_SHIFT);
  assign bit_out     = bit_valid && cur_bit;
  assign done        = (state_q == S_DONE);
  assign match_pulse = pulse_q;
  assign match_count = count_q;

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Bench for seq_det_ctrl: a frame-level bit-stream model checks two instances (8-bit and 2-bit counters)
// every cycle, plus directed scenarios with hand-computed results.
`timescale 1ns/1ps
module tb_seq_det_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  cfg_pattern;
  logic [3:0]  cfg_len;
  logic        cfg_overlap;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_last;

  logic        in_ready, bit_out, bit_valid, match_pulse, done, cfg_err;
  logic [7:0]  match_count;
  logic        s_in_ready, s_bit_out, s_bit_valid, s_match_pulse, s_done, s_cfg_err;
  logic [1:0]  s_match_count;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  seq_det_ctrl u_dut (
    .clk(clk), .reset(reset), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .cfg_overlap(cfg_overlap), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(in_ready), .bit_out(bit_out), .bit_valid(bit_valid),
    .match_pulse(match_pulse), .match_count(match_count), .done(done), .cfg_err(cfg_err)
  );

  seq_det_ctrl #(.CNT_W(2)) u_sat (
    .clk(clk), .reset(reset), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .cfg_overlap(cfg_overlap), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(s_in_ready), .bit_out(s_bit_out), .bit_valid(s_bit_valid),
    .match_pulse(s_match_pulse), .match_count(s_match_count), .done(s_done), .cfg_err(s_cfg_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model: a frame is a list of bits ----------------
  int       m_bits_left;
  logic [15:0] m_word;
  bit       m_last, m_done_now, m_pulse_now, m_open, m_ovl;
  logic [7:0] m_pat;
  int       m_len, m_start, m_cnt;
  bit       fbits[$];
  bit       m_bit, m_match, m_acc, m_idle;
  int       m_n;

  function automatic bit exp_cfg_err();
    return !m_open && (cfg_len == 4'd0 || cfg_len > 4'd8);
  endfunction

  function automatic bit exp_ready();
    return reset && m_bits_left == 0 && !m_done_now && !exp_cfg_err();
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_bits_left = 0; m_done_now = 0; m_pulse_now = 0; m_open = 0;
      m_cnt = 0; m_start = 0; fbits.delete();
    end else begin
      m_idle = (m_bits_left == 0) && !m_done_now;
      m_acc  = m_idle && in_valid && exp_ready();
      m_pulse_now = 0;
      m_done_now  = 0;
      if (m_bits_left > 0) begin
        m_bit = m_word[m_bits_left-1];
        fbits.push_back(m_bit);
        m_n = fbits.size();
        m_match = (m_n - m_start >= m_len);
        for (int j = 0; j < m_len; j++)
          if (m_match && fbits[m_n-1-j] != m_pat[j]) m_match = 0;
        if (m_match) begin
          m_pulse_now = 1;
          m_cnt++;
          if (!m_ovl) m_start = m_n;
        end
        m_bits_left--;
        if (m_bits_left == 0 && m_last) begin
          m_done_now = 1;
          m_open = 0;
        end
      end else if (m_acc) begin
        if (!m_open) begin
          m_open = 1; m_pat = cfg_pattern; m_len = int'(cfg_len); m_ovl = cfg_overlap;
          m_cnt = 0; m_start = 0; fbits.delete();
        end
        m_word = in_data; m_last = in_last; m_bits_left = 16;
      end
    end
  end

  // One compare process, away from the active edge.
  always @(negedge clk) begin
    logic exp_bit;
    exp_bit = (m_bits_left > 0) ? m_word[m_bits_left-1] : 1'b0;
    check("in_ready",    in_ready,    exp_ready());
    check("bit_valid",   bit_valid,   m_bits_left > 0);
    check("bit_out",     bit_out,     exp_bit);
    check("match_pulse", match_pulse, m_pulse_now);
    check("done",        done,        m_done_now);
    check("cfg_err",     cfg_err,     exp_cfg_err());
    check("match_count", match_count, (m_cnt > 255) ? 255 : m_cnt);
    check("sat_in_ready",    s_in_ready,    exp_ready());
    check("sat_bit_out",     {s_bit_valid, s_bit_out}, {m_bits_left > 0, exp_bit});
    check("sat_pulse_done",  {s_match_pulse, s_done, s_cfg_err}, {m_pulse_now, m_done_now, exp_cfg_err()});
    check("sat_match_count", s_match_count, (m_cnt > 3) ? 3 : m_cnt);
  end

  // Event counters for directed scenarios.
  int pulse_seen, valid_seen, done_seen;
  always @(negedge clk) begin
    if (match_pulse) pulse_seen++;
    if (bit_valid)   valid_seen++;
    if (done)        done_seen++;
  end

  // ---------------- stimulus helpers (called at posedge+1) ----------------
  task automatic send_word(input logic [15:0] d, input logic l);
    in_data = d; in_last = l; in_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk); #1;
        in_valid = 1'b0;
        return;
      end
    end
    check("send_word_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input string name, input bit do_check, input int exp_cnt, input int exp_sat);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (done) begin
        if (do_check) begin
          check({name, "_count"}, match_count, exp_cnt);
          check({name, "_sat"}, s_match_count, exp_sat);
        end
        @(posedge clk); #1;
        return;
      end
    end
    check({name, "_done_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic set_cfg(input logic [7:0] p, input logic [3:0] len, input logic ovl);
    cfg_pattern = p; cfg_len = len; cfg_overlap = ovl;
  endtask

  task automatic clear_counts();
    pulse_seen = 0; valid_seen = 0; done_seen = 0;
  endtask

  initial begin
    reset = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    set_cfg(8'h0D, 4'd4, 1'b0);
    #12;
    check("reset_in_ready", in_ready, 1'b0);
    check("reset_outputs", {bit_valid, bit_out, match_pulse, done}, 4'b0);
    check("reset_count", match_count, 8'd0);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;

    // 1: two non-overlapping matches in one word.
    clear_counts();
    send_word(16'h0D0D, 1'b1);
    wait_done("t1", 1, 2, 2);
    @(negedge clk);
    check("t1_valid_cycles", valid_seen, 16);
    check("t1_pulses", pulse_seen, 2);
    @(posedge clk); #1;

    // 2: match spanning a word boundary.
    clear_counts();
    send_word(16'h0003, 1'b0);
    send_word(16'h4000, 1'b1);
    wait_done("t2", 1, 1, 1);
    @(negedge clk);
    check("t2_pulses", pulse_seen, 1);
    @(posedge clk); #1;

    // 3: overlap versus non-overlap on 0110_1101.
    set_cfg(8'h0D, 4'd4, 1'b1);
    send_word(16'h006D, 1'b1);
    wait_done("t3_ovl", 1, 2, 2);
    set_cfg(8'h0D, 4'd4, 1'b0);
    send_word(16'h006D, 1'b1);
    wait_done("t3_novl", 1, 1, 1);

    // 4: saturation of the 2-bit counter; the 8-bit one keeps counting.
    clear_counts();
    set_cfg(8'h01, 4'd1, 1'b0);
    send_word(16'hFFFF, 1'b1);
    wait_done("t4", 1, 16, 3);
    @(negedge clk);
    check("t4_pulses", pulse_seen, 16);
    @(posedge clk); #1;

    // 5: illegal length blocks acceptance until fixed.
    set_cfg(8'h0D, 4'd0, 1'b0);
    in_data = 16'h0D0D; in_last = 1'b1; in_valid = 1'b1;
    repeat (3) @(negedge clk);
    check("t5_cfg_err", cfg_err, 1'b1);
    check("t5_in_ready", in_ready, 1'b0);
    check("t5_bit_valid", bit_valid, 1'b0);
    @(posedge clk); #1;
    cfg_len = 4'd4;
    @(negedge clk);
    check("t5_ready_after_fix", in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("t5_accepted", bit_valid, 1'b1);
    wait_done("t5", 1, 2, 2);

    // 6: reset mid-shift aborts silently, then a fresh frame works.
    send_word(16'h0D0D, 1'b1);
    repeat (7) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("t6_outputs_zero", {in_ready, bit_valid, bit_out, match_pulse, done}, 5'b0);
    check("t6_count_zero", match_count, 8'd0);
    clear_counts();
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (25) @(negedge clk);
    check("t6_no_done", done_seen, 0);
    @(posedge clk); #1;
    send_word(16'h0D0D, 1'b1);
    wait_done("t6", 1, 2, 2);

    // Random frames: config may wander (even illegally) between words of an open frame.
    for (int f = 0; f < 40; f++) begin
      int nwords;
      logic [7:0] p;
      p = 8'($urandom);
      set_cfg(p, 4'($urandom_range(1, 8)), 1'($urandom));
      nwords = $urandom_range(1, 3);
      for (int w = 0; w < nwords; w++) begin
        logic [15:0] d;
        d = ($urandom_range(0, 1) == 1) ? {cfg_pattern, cfg_pattern} : 16'($urandom);
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        send_word(d, w == nwords - 1);
        if (w != nwords - 1) set_cfg(8'($urandom), 4'($urandom_range(0, 15)), 1'($urandom));
      end
      wait_done("rand", 0, 0, 0);
    end

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_det_ctrl.md
Name: seq_det_ctrl

Overview:
- Controller that sequences a serial pattern-detection datapath.
- Accepts parallel words over a valid/ready handshake and serialises each word MSB-first, one bit per cycle.
- Runs a programmable pattern match (1..PAT_W bits, overlapping or non-overlapping) across word boundaries within a frame.
- Reports per-match pulses and a frame match count. It sits between the word-level producer and the bit-serial detector logic.

Parameters:
- DATA_W, 16: bits per input word.
- PAT_W, 8: maximum pattern length.
- CNT_W, 8: match counter width (saturating).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- cfg_pattern  in  PAT_W  pattern; bit [cfg_len-1] is the first bit expected, bit 0 the last.
- cfg_len  in  4  pattern length; legal range 1..PAT_W.
- cfg_overlap  in  1  1 = overlapping matches allowed.
- in_valid  in  1  word available.
- in_data  in  DATA_W  word to serialise.
- in_last  in  1  word is the final word of the frame.
- in_ready  out  1  controller can accept a word.
- bit_out  out  1  current serial bit.
- bit_valid  out  1  bit_out is valid this cycle.
- match_pulse  out  1  one-cycle pulse per detected match.
- match_count  out  CNT_W  matches in the current or last frame.
- done  out  1  one-cycle pulse at frame end.
- cfg_err  out  1  configuration illegal.

Behaviour:
- Reset (reset=0, asynchronous):
  - FSM goes to IDLE; frame closed.
  - History, bit counter and match_count clear to 0.
  - in_ready=0 during reset. bit_out=0, bit_valid=0, match_pulse=0, done=0.
  - Reset during SHIFT aborts the frame silently: no done pulse.
- FSM states:
  - IDLE: in_ready=1 unless cfg_err. A transfer (in_valid & in_ready) latches in_data and in_last, then goes to SHIFT.
  - SHIFT: lasts exactly DATA_W cycles. Cycle k presents word[DATA_W-1-k] on bit_out with bit_valid=1, and in_ready=0.
    - After cycle DATA_W-1: go to DONE if the latched last=1, else to IDLE.
  - DONE: one cycle, then IDLE.
- Inter-word gap: a minimum of one bubble cycle (IDLE) between words of the same frame.
- Frame start:
  - The first transfer while the frame is closed opens the frame.
  - That transfer samples cfg_pattern, cfg_len and cfg_overlap into shadow registers; config changes mid-frame are ignored.
  - It also clears match_count, the history shift register and seen_cnt.
- Detection, per serial bit:
  - hist <= {hist[PAT_W-2:0], bit}; seen_cnt increments, saturating at PAT_W.
  - A match occurs when seen_cnt (including the current bit) >= len and hist_new[len-1:0] == pattern[len-1:0].
  - Non-overlap mode: on a match, seen_cnt clears to 0, so the next match needs len fresh bits.
  - Overlap mode: seen_cnt is unaffected by a match.
- Match outputs:
  - match_pulse is registered: it asserts the cycle after the bit that completes the match.
  - match_count increments in that same cycle and saturates at 2^CNT_W-1.
- Frame end:
  - done asserts in the DONE-state cycle, i.e. the cycle after the final bit. That cycle coincides with any match_pulse caused by the final bit.
  - At done, match_count already includes that final match and holds until the next frame opens.
- History and seen_cnt persist across words of one frame, so matches can span word boundaries.
- cfg_err:
  - Combinational. Equals 1 when the frame is closed and (cfg_len==0 or cfg_len>PAT_W).
  - While cfg_err=1 in IDLE with the frame closed, in_ready=0 and no word is accepted.
  - Mid-frame, the shadow config governs and cfg_err=0.
- in_valid high with in_ready=0: no transfer; the producer must hold the data.

Test Plan:
1. len=4, pat=4'b1101, overlap=0, in_data=16'h0D0D, in_last=1 -> 16 bit_valid cycles, two match_pulses, done with match_count=2.
2. Cross-word: word 16'h0003 (last=0), then 16'h4000 (last=1) -> exactly one match_pulse, one cycle after bit 1 of the second word; done with match_count=1.
3. Overlap: 16'h006D, last=1, len=4, pat=1101 -> overlap=1 gives match_count=2; repeated with overlap=0 gives match_count=1.
4. Saturation: CNT_W=2, len=1, pat=1, 16'hFFFF, last=1 -> 16 match_pulses, match_count sticks at 3.
5. cfg_len=0 with in_valid=1 -> cfg_err=1, in_ready=0, no bit_valid. Setting cfg_len=4 -> word is accepted the next cycle.
6. reset driven to 0 at SHIFT bit 7 -> all outputs go to 0 immediately, no done. After release, a new frame with 16'h0D0D gives match_count=2.
